// File: rtl/grayscale_pixel_packer.sv
// rtl/grayscale_pixel_packer.sv - custom instruction packing 8-bit gray pixels into 32-bit words queued in a FIFO
module grayscale_pixel_packer #(
  parameter logic [7:0] customInstructionId = 8'h00,
  parameter int         fifoDepth           = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  iseId,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int         PW        = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(fifoDepth);

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_POP    = 2'd1;
  localparam logic [1:0] OP_STATUS = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  logic [31:0]   mem [fifoDepth];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [4:0]    count, count_n;
  logic [1:0]    lane_cnt, lane_cnt_n;
  logic [23:0]   pack, pack_n;
  logic          overflow, overflow_n;
  logic          underflow, underflow_n;
  logic          done_n;
  logic [31:0]   result_n;
  logic          wr_en;
  logic [31:0]   wr_word;
  logic          accept;

  logic unused_operand_bits;
  assign unused_operand_bits = ^{valueA[31:8], valueB[31:2]};

  function automatic logic [31:0] status_word(input logic [4:0] cnt, input logic [1:0] lane,
                                              input logic ovf, input logic unf);
    logic [31:0] s;
    s        = '0;
    s[4:0]   = cnt;
    s[6:5]   = lane;
    s[8]     = (cnt == 5'd0);
    s[9]     = (cnt == DEPTH_CNT);
    s[10]    = ovf;
    s[11]    = unf;
    return s;
  endfunction

  assign accept = start && (iseId == customInstructionId);

  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    lane_cnt_n  = lane_cnt;
    pack_n      = pack;
    overflow_n  = overflow;
    underflow_n = underflow;
    wr_en       = 1'b0;
    wr_word     = {valueA[7:0], pack};
    done_n      = 1'b0;
    result_n    = '0;
    if (accept) begin
      done_n = 1'b1;
      case (valueB[1:0])
        OP_PUSH: begin
          if (lane_cnt == 2'd3) begin
            // Fourth pixel completes the word; a full FIFO drops it but the lane still restarts.
            if (count == DEPTH_CNT) begin
              overflow_n = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_ptr_n = wr_ptr + PW'(1);
              count_n  = count + 5'd1;
            end
            lane_cnt_n = 2'd0;
          end else begin
            case (lane_cnt)
              2'd0:    pack_n[7:0]   = valueA[7:0];
              2'd1:    pack_n[15:8]  = valueA[7:0];
              default: pack_n[23:16] = valueA[7:0];
            endcase
            lane_cnt_n = lane_cnt + 2'd1;
          end
          result_n = status_word(count_n, lane_cnt_n, overflow_n, underflow_n);
        end
        OP_POP: begin
          if (count != 5'd0) begin
            result_n = mem[rd_ptr];
            rd_ptr_n = rd_ptr + PW'(1);
            count_n  = count - 5'd1;
          end else begin
            underflow_n = 1'b1;
          end
        end
        OP_STATUS: result_n = status_word(count, lane_cnt, overflow, underflow);
        OP_CLEAR: begin
          wr_ptr_n    = '0;
          rd_ptr_n    = '0;
          count_n     = '0;
          lane_cnt_n  = '0;
          pack_n      = '0;
          overflow_n  = 1'b0;
          underflow_n = 1'b0;
        end
        default: result_n = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lane_cnt  <= '0;
      pack      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      lane_cnt  <= lane_cnt_n;
      pack      <= pack_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      done      <= done_n;
      result    <= result_n;
    end
  end

  // Storage needs no reset: the fill count guards every read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

endmodule
